local_inject_ctrl: RTL
======================

LOCAL_INJECT_CTRL -- requirements
Module: local_inject_ctrl

Interface
REQ-001 The block SHALL expose parameter WIDTH_PORT, default `WIDTH_PORT, meaning the flit width in bits.
REQ-002 The block SHALL expose parameter WIDTH_PV, default `WIDTH_PV (5), meaning the productive-vector width.
REQ-003 The block SHALL expose parameter DEPTH, default 4, meaning the injection queue entries (power of 2, >=2).
REQ-004 The block SHALL expose parameter STARVE_TH, default 15, meaning consecutive blocked cycles before starvation (1..255).
REQ-005 The block SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset  in  1  meaning the reset, asynchronous and active-high.
REQ-007 The block SHALL have port pe_valid  in  1  meaning the PE offers a flit.
REQ-008 The block SHALL have port pe_flit  in  WIDTH_PORT  meaning the offered flit.
REQ-009 The block SHALL have port pe_pv  in  WIDTH_PV  meaning the productive vector of the offered flit.
REQ-010 The block SHALL have port pe_ready  out  1  meaning the queue can accept a flit.
REQ-011 The block SHALL have port localReq  out  1  meaning the head flit is pending injection.
REQ-012 The block SHALL have port dinLocal  out  WIDTH_PORT  meaning the head flit to the router inject mux.
REQ-013 The block SHALL have port PVLocal  out  WIDTH_PV  meaning the head flit productive vector.
REQ-014 The block SHALL have port injectGrant  in  1  meaning the router placed dinLocal into a channel this cycle (OR of injectVector).
REQ-015 The block SHALL have port starve  out  1  meaning the head has been blocked STARVE_TH cycles; the router throttles bypass injection.
REQ-016 The block SHALL have port occupancy  out  clog2(DEPTH)+1  meaning the number of queued flits.
REQ-017 The block SHALL have port dropPulse  out  1  meaning a one-cycle pulse when an accepted flit with pe_pv==0 is discarded.

Function
REQ-018 The block SHALL push when pe_valid && pe_ready && pe_pv!=0, storing {pe_flit, pe_pv} at the tail.
REQ-019 The block SHALL accept and not store a flit when pe_valid && pe_ready && pe_pv==0, and assert dropPulse in the following cycle.
REQ-020 The block SHALL drive pe_ready = (occupancy < DEPTH), combinationally from registered occupancy, with no same-cycle pop bypass.
REQ-021 The block SHALL drive localReq = (occupancy != 0), and dinLocal/PVLocal from the head entry; both SHALL be all-zero while empty.
REQ-022 The block SHALL pop the head when injectGrant && localReq; injectGrant while empty SHALL be ignored with no state change.
REQ-023 The block SHALL make a pushed flit visible on localReq/dinLocal exactly 1 cycle after the accepting edge, with no empty-queue bypass.
REQ-024 The block SHALL, on a simultaneous push and pop, keep occupancy unchanged, advance both head and tail, and present the next entry as head.
REQ-025 The block SHALL wrap pointers modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow below 0.
REQ-026 The block SHALL implement an FSM with states IDLE (empty), WAIT (head pending, blkCnt<STARVE_TH) and STARVED.
REQ-027 The block SHALL use these FSM transitions: IDLE->WAIT on the queue becoming non-empty; WAIT->STARVED when blkCnt reaches STARVE_TH; WAIT/STARVED->WAIT on a pop leaving the queue non-empty; WAIT/STARVED->IDLE on a pop emptying the queue.
REQ-028 The block SHALL increment blkCnt (8-bit, saturating at STARVE_TH) each cycle with localReq && !injectGrant, and clear it on any pop or while empty.
REQ-029 The block SHALL drive starve = (state==STARVED) as a registered output, deasserting the cycle after the granting pop.

Reset
REQ-030 The block SHALL, while reset=1, asynchronously force pointers=0, occupancy=0, blkCnt=0, state=IDLE, dropPulse=0, starve=0.
REQ-031 The block SHALL hold pe_ready=1, localReq=0, dinLocal=0 and PVLocal=0 during reset.
REQ-032 The block SHALL, on reset asserted mid-operation, discard queued flits; the first post-reset push SHALL appear at head 1 cycle later.

Verification
REQ-033 The bench SHALL cover single push: pe_flit=0xA5, pe_pv=5'b00010 at cycle 0 -> localReq=1, dinLocal=0xA5, PVLocal=5'b00010 at cycle 1; injectGrant at cycle 1 -> localReq=0 at cycle 2.
REQ-034 The bench SHALL cover fill: 4 pushes, no grant -> occupancy=4, pe_ready=0; a 5th pe_valid is not accepted; one grant -> pe_ready=1 the next cycle.
REQ-035 The bench SHALL cover starvation: head pending, injectGrant=0 for 15 cycles -> starve=1 on cycle 16; grant -> starve=0 next cycle, blkCnt=0.
REQ-036 The bench SHALL cover simultaneous events: occupancy=2 with push+grant in the same cycle -> occupancy stays 2, head=old second entry, FIFO order preserved.
REQ-037 The bench SHALL cover the zero-PV drop: pe_pv=0 accepted -> dropPulse=1 for one cycle, occupancy unchanged.
REQ-038 The bench SHALL cover reset mid-operation: occupancy=3 and starve=1, reset pulsed -> occupancy=0, starve=0, localReq=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/local_inject_ctrl_if.sv
// PE-to-router local injection bundle: PE offer handshake, head-of-queue view and status.
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif
`ifndef WIDTH_PV
`define WIDTH_PV 5
`endif

interface local_inject_ctrl_if #(
  parameter int WIDTH_PORT = `WIDTH_PORT,
  parameter int WIDTH_PV   = `WIDTH_PV,
  parameter int DEPTH      = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  pe_valid;
  logic [WIDTH_PORT-1:0] pe_flit;
  logic [WIDTH_PV-1:0]   pe_pv;
  logic                  pe_ready;
  logic                  localReq;
  logic [WIDTH_PORT-1:0] dinLocal;
  logic [WIDTH_PV-1:0]   PVLocal;
  logic                  injectGrant;
  logic                  starve;
  logic [OCC_W-1:0]      occupancy;
  logic                  dropPulse;

  modport slave (
    input  pe_valid, pe_flit, pe_pv, injectGrant,
    output pe_ready, localReq, dinLocal, PVLocal, starve, occupancy, dropPulse
  );

  modport master (
    output pe_valid, pe_flit, pe_pv, injectGrant,
    input  pe_ready, localReq, dinLocal, PVLocal, starve, occupancy, dropPulse
  );
endinterface

// File: rtl/local_inject_ctrl.sv
// Local injection queue between a PE and the router: FIFO of {flit, pv}, zero-PV drop,
// starvation detection. Push visible 1 cycle later; pe_ready low when full (no pop bypass).
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif
`ifndef WIDTH_PV
`define WIDTH_PV 5
`endif

module local_inject_ctrl #(
  parameter int WIDTH_PORT = `WIDTH_PORT,
  parameter int WIDTH_PV   = `WIDTH_PV,
  parameter int DEPTH      = 4,
  parameter int STARVE_TH  = 15
) (
  input logic           clk,
  input logic           reset,
  local_inject_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = WIDTH_PORT + WIDTH_PV;

  typedef enum logic [1:0] {IDLE, WAIT, STARVED} state_t;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [7:0]       blk_q, blk_d;
  state_t           state_q;
  logic             starve_q;
  logic             drop_q;
  logic             accept, push, pop;

  assign bus.pe_ready  = (occ_q < OCC_W'(DEPTH));
  assign bus.localReq  = (occ_q != '0);
  assign accept        = bus.pe_valid && bus.pe_ready;
  assign push          = accept && (bus.pe_pv != '0);
  assign pop           = bus.injectGrant && bus.localReq;
  assign {bus.dinLocal, bus.PVLocal} = bus.localReq ? mem_q[head_q] : '0;
  assign bus.occupancy = occ_q;
  assign bus.starve    = starve_q;
  assign bus.dropPulse = drop_q;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Blocked-cycle counter saturates at the threshold; any pop or an empty queue clears it.
  always_comb begin
    blk_d = 8'd0;
    if (bus.localReq && !bus.injectGrant)
      blk_d = (blk_q >= 8'(STARVE_TH)) ? blk_q : blk_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[tail_q] <= {bus.pe_flit, bus.pe_pv};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      blk_q    <= 8'd0;
      drop_q   <= 1'b0;
      state_q  <= IDLE;
      starve_q <= 1'b0;
    end else begin
      if (push)
        tail_q <= tail_q + PTR_W'(1);
      if (pop)
        head_q <= head_q + PTR_W'(1);
      occ_q  <= occ_d;
      blk_q  <= blk_d;
      drop_q <= accept && (bus.pe_pv == '0);

      case (state_q)
        IDLE: begin
          if (occ_d != '0)
            state_q <= WAIT;
        end
        WAIT: begin
          if (pop) begin
            state_q <= (occ_d == '0) ? IDLE : WAIT;
          end else if (blk_d >= 8'(STARVE_TH)) begin
            state_q  <= STARVED;
            starve_q <= 1'b1;
          end
        end
        STARVED: begin
          if (pop) begin
            state_q  <= (occ_d == '0) ? IDLE : WAIT;
            starve_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          starve_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
